// File: rtl/sram_cp_pkg.sv
// Shared types, widths and state encodings for the SRAM compute-in-memory
// controller and its WAIT timer.
package sram_cp_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int SEL_W  = 16;
  localparam int Q_W    = 192;
  localparam int IN_W   = 8;
  localparam int IDX_W  = 3;
  localparam int CNT_W  = 4;

  typedef enum logic {
    OP_WR   = 1'b0,
    OP_COMP = 1'b1
  } op_e;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_WR   = 3'd1;
  localparam state_t S_SET  = 3'd2;
  localparam state_t S_COMP = 3'd3;
  localparam state_t S_WAIT = 3'd4;
  localparam state_t S_SAMP = 3'd5;
  localparam state_t S_HOLD = 3'd6;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [IN_W-1:0]   vec;
    logic [IDX_W-1:0]  nbits;
    logic [SEL_W-1:0]  sel;
  } cmd_t;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic [SEL_W-1:0]  sel_array;
    logic              set;
    logic              comp;
    logic              inbit;
    logic              wait_;
    logic              model;
    logic              col_en;
    logic              reg_en;
    logic              wrt;
  } drive_t;

  // States in which the macro is held in compute mode (SET through HOLD).
  function automatic logic in_compute(input state_t s);
    return (s == S_SET) || (s == S_COMP) || (s == S_WAIT) ||
           (s == S_SAMP) || (s == S_HOLD);
  endfunction

  function automatic logic plane_is_last(input logic [IDX_W-1:0] idx,
                                         input logic [IDX_W-1:0] nbits);
    return idx == nbits;
  endfunction

endpackage

// File: rtl/sram_cp_timer.sv
// Loadable down-counter that times the charge-settle (WAIT) phase; done is
// raised while the count sits at one, i.e. in the last enabled cycle.
module sram_cp_timer
  import sram_cp_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Load has priority; decrement saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != {CNT_W{1'b0}})) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/sram_cp_ctrl.sv
// Sequencer for an SRAM compute-in-memory macro: single-cycle row writes and
// bit-serial compute (SET/COMP/WAIT/SAMP per plane) with a held result handshake.
module sram_cp_ctrl
  import sram_cp_pkg::*;
#(
  parameter int unsigned WAIT_CYC = 2
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [IN_W-1:0]   cmd_in,
  input  logic [IDX_W-1:0]  cmd_nbits,
  input  logic [SEL_W-1:0]  cmd_sel,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [Q_W-1:0]    rsp_data,
  output logic [IDX_W-1:0]  rsp_idx,
  output logic              rsp_last,
  output logic [ADDR_W-1:0] a,
  output logic [DATA_W-1:0] d,
  output logic [SEL_W-1:0]  sel_array,
  output logic              set,
  output logic              comp,
  output logic              inbit,
  output logic              wait_,
  output logic              model,
  output logic              col_en,
  output logic              reg_en,
  output logic              wrt,
  input  logic [Q_W-1:0]    q
);

  state_t           state_q;
  state_t           state_d;
  cmd_t             cmd_q;
  cmd_t             cmd_d;
  logic [IDX_W-1:0] bit_idx_q;
  logic [IDX_W-1:0] bit_idx_d;
  drive_t           drv_q;
  drive_t           drv_d;
  logic             rsp_valid_q;
  logic [Q_W-1:0]   rsp_data_q;
  logic [IDX_W-1:0] rsp_idx_q;
  logic             rsp_last_q;
  logic             tmr_done;

  sram_cp_timer u_timer (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (state_q == S_COMP),
    .load_val_i (CNT_W'(WAIT_CYC)),
    .en_i       (state_q == S_WAIT),
    .done_o     (tmr_done)
  );

  // Next state, command latch and bit-plane index.
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    bit_idx_d = bit_idx_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          cmd_d.addr  = cmd_addr;
          cmd_d.data  = cmd_data;
          cmd_d.vec   = cmd_in;
          cmd_d.nbits = cmd_nbits;
          cmd_d.sel   = cmd_sel;
          bit_idx_d   = {IDX_W{1'b0}};
          state_d     = (cmd_op == OP_COMP) ? S_SET : S_WR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WR:   state_d = S_IDLE;
      S_SET:  state_d = S_COMP;
      S_COMP: state_d = S_WAIT;
      S_WAIT: begin
        if (tmr_done) begin
          state_d = S_SAMP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_SAMP: state_d = S_HOLD;
      S_HOLD: begin
        if (rsp_ready && rsp_last_q) begin
          state_d = S_IDLE;
        end else if (rsp_ready) begin
          bit_idx_d = bit_idx_q + IDX_W'(1);
          state_d   = S_SET;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Macro drive decoded from the next state so the pins come straight off flops.
  always_comb begin
    drv_d = '0;
    if (state_d != S_IDLE) begin
      drv_d.a = cmd_d.addr;
    end else begin
      drv_d.a = {ADDR_W{1'b0}};
    end
    if (in_compute(state_d)) begin
      drv_d.model     = 1'b1;
      drv_d.sel_array = cmd_d.sel;
      drv_d.inbit     = cmd_d.vec[bit_idx_d];
    end else begin
      drv_d.model     = 1'b0;
      drv_d.sel_array = {SEL_W{1'b0}};
      drv_d.inbit     = 1'b0;
    end
    case (state_d)
      S_WR: begin
        drv_d.wrt    = 1'b1;
        drv_d.col_en = 1'b1;
        drv_d.d      = cmd_d.data;
      end
      S_SET:   drv_d.set    = 1'b1;
      S_COMP:  drv_d.comp   = 1'b1;
      S_WAIT:  drv_d.wait_  = 1'b1;
      S_SAMP:  drv_d.reg_en = 1'b1;
      default: drv_d.wrt    = 1'b0;
    endcase
  end

  // Control state, latched command and registered macro drive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cmd_q     <= '0;
      bit_idx_q <= {IDX_W{1'b0}};
      drv_q     <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      bit_idx_q <= bit_idx_d;
      drv_q     <= drv_d;
    end
  end

  // Result capture at the end of SAMP; held untouched through HOLD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= {Q_W{1'b0}};
      rsp_idx_q   <= {IDX_W{1'b0}};
      rsp_last_q  <= 1'b0;
    end else begin
      rsp_valid_q <= (state_d == S_HOLD);
      if (state_q == S_SAMP) begin
        rsp_data_q <= q;
        rsp_idx_q  <= bit_idx_q;
        rsp_last_q <= plane_is_last(bit_idx_q, cmd_q.nbits);
      end else begin
        rsp_data_q <= rsp_data_q;
        rsp_idx_q  <= rsp_idx_q;
        rsp_last_q <= rsp_last_q;
      end
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_idx   = rsp_idx_q;
  assign rsp_last  = rsp_last_q;
  assign a         = drv_q.a;
  assign d         = drv_q.d;
  assign sel_array = drv_q.sel_array;
  assign set       = drv_q.set;
  assign comp      = drv_q.comp;
  assign inbit     = drv_q.inbit;
  assign wait_     = drv_q.wait_;
  assign model     = drv_q.model;
  assign col_en    = drv_q.col_en;
  assign reg_en    = drv_q.reg_en;
  assign wrt       = drv_q.wrt;

endmodule

// File: doc/sram_cp_ctrl.md
SRAM_CP_CTRL -- requirements
Module: sram_cp_ctrl

Interface
REQ-001 Parameter: WAIT_CYC, default 2, charge-settle cycles with wait_ high; legal range 1..15.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 cmd_valid  input  1  host command offered.
REQ-005 cmd_ready  output  1  controller accepts a command (IDLE only).
REQ-006 cmd_op  input  1  0 = row write, 1 = bit-serial compute.
REQ-007 cmd_addr  input  8  macro row address.
REQ-008 cmd_data  input  32  write data (write op).
REQ-009 cmd_in  input  8  input vector bits, LSB first (compute op).
REQ-010 cmd_nbits  input  3  compute bit count minus one (0 = 1 bit, 7 = 8 bits).
REQ-011 cmd_sel  input  16  array select for compute.
REQ-012 rsp_valid  output  1  bit-plane result available.
REQ-013 rsp_ready  input  1  host takes result.
REQ-014 rsp_data  output  192  captured macro q.
REQ-015 rsp_idx  output  3  bit index of rsp_data.
REQ-016 rsp_last  output  1  rsp_data is the final bit-plane of the command.
REQ-017 Macro drive outputs: a[8], d[32], sel_array[16], set, comp, inbit, wait_, model, col_en, reg_en, wrt (1 bit each unless sized); macro q[192] input.

Function
REQ-018 States: IDLE, WR, SET, COMP, WAIT, SAMP, HOLD.
REQ-019 IDLE: cmd_ready=1; on cmd_valid latch all cmd fields; op=0 -> WR, op=1 -> SET with bit_idx=0.
REQ-020 WR: wrt=1, col_en=1 for exactly one cycle, a/d = latched addr/data -> IDLE; write accepted at edge N gives wrt high in cycle N+1, cmd_ready high again in cycle N+2.
REQ-021 SET: set=1 one cycle -> COMP; COMP: comp=1 one cycle -> WAIT.
REQ-022 WAIT: wait_=1 for exactly WAIT_CYC cycles (down-counter) -> SAMP.
REQ-023 SAMP: reg_en=1 one cycle; rsp_data <= q at end of cycle; rsp_idx <= bit_idx; rsp_last <= (bit_idx==nbits) -> HOLD.
REQ-024 HOLD: rsp_valid=1, rsp_data/idx/last stable until rsp_ready; on rsp_ready: last -> IDLE, else bit_idx+1 -> SET.
REQ-025 Compute op total latency per bit-plane absent backpressure: 3+WAIT_CYC cycles from SET entry to rsp_valid.
REQ-026 model=1 and sel_array=latched sel in every state SET..HOLD; 0 otherwise.
REQ-027 inbit = latched cmd_in[bit_idx] in SET..HOLD; 0 otherwise.
REQ-028 a = latched addr in all non-IDLE states; d = latched data only in WR, else 0.
REQ-029 set, comp, wait_, reg_en, wrt, col_en mutually exclusive; never two high in one cycle.
REQ-030 cmd_valid outside IDLE ignored (cmd_ready=0); rsp_ready outside HOLD ignored.
REQ-031 nbits=0: single plane, rsp_last=1 on first response; nbits=7: eight planes, idx 0..7.

Reset
REQ-032 rst high at any time (including mid-compute or in HOLD) forces IDLE; all macro drive outputs 0; rsp_valid=0, rsp_data=0, rsp_idx=0, rsp_last=0; counters and latched fields 0; cmd_ready=1 from first cycle after rst deasserts.
REQ-033 No partial pulse (set/comp/wrt) may persist past rst assertion.

Structure
REQ-034 Package sram_cp_pkg holds state enum, op encodings (OP_WR, OP_COMP), widths ADDR_W=8, DATA_W=32, SEL_W=16, Q_W=192.
REQ-035 One sub-module sram_cp_timer: loadable 4-bit down-counter with done flag, used for WAIT.

Verification
REQ-036 Write: op=0, addr=0x3A, data=0xDEADBEEF -> wrt=col_en=1 one cycle, a=0x3A, d=0xDEADBEEF, cmd_ready back two cycles after accept.
REQ-037 Compute: op=1, in=0xA5, nbits=7, sel=0x0F0F, rsp_ready tied 1, WAIT_CYC=2 -> eight responses idx 0..7, inbit sequence 1,0,1,0,0,1,0,1, rsp_last only on idx 7, 5 cycles between SET entry and each rsp_valid.
REQ-038 Backpressure: rsp_ready low 10 cycles in HOLD -> rsp_data/idx stable, no set/comp pulses, next SET only after handshake.
REQ-039 Reset mid-WAIT (compute, bit_idx=3) -> all outputs 0 next cycle, IDLE, following write completes normally.
REQ-040 Command during compute: cmd_valid held with cmd_ready=0 -> ignored until IDLE, then accepted once; one-hot check of REQ-029 asserted throughout all tests.
